reg_file: RTL and testbench

- Integer register file for the single-cycle RISC-V core; sits directly downstream of the Hot_Bit one-hot decoder.
- Hot_Bit converts the rd index into per-register write strobes; reg_file consumes those strobes to update the storage array.
- Provides two combinational read ports (rs1, rs2), one synchronous write port and one debug read port.
- x0 is hardwired to zero.

---
 rtl/riscv_pkg.sv | 12 +
 rtl/reg_file_hot_bit.sv | 14 +
 rtl/reg_file.sv | 66 ++++++
 tb/tb_reg_file.sv | 131 +++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core-wide types and sizes for the integer datapath.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_ZERO   = 0;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_hot_bit.sv
// Hot_Bit: binary index to one-hot strobe decoder feeding the register file.
module Hot_Bit #(
  parameter  int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DEPTH-1:0]  onehot
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dec
    assign onehot[gi] = (addr == ADDR_W'(gi));
  end

endmodule

// File: rtl/reg_file.sv
// Integer register file: two combinational read ports with optional write
// forwarding, one synchronous write port, one committed-state debug port.
module reg_file
  import riscv_pkg::*;
#(
  parameter  int DEPTH  = NUM_REGS,
  parameter  int WIDTH  = XLEN,
  parameter  int BYPASS = 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata1,
  output logic [WIDTH-1:0]  rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DEPTH-1:0] onehot;
  logic [DEPTH-1:0] wr_en;
  logic [WIDTH-1:0] regs [1:DEPTH-1];
  logic [WIDTH-1:0] rows [DEPTH];
  logic             byp1;
  logic             byp2;
  logic             wr_live;

  Hot_Bit #(.DEPTH(DEPTH)) u_hot_bit (
    .addr   (waddr),
    .onehot (onehot)
  );

  assign wr_en = {DEPTH{we}} & onehot;

  always_ff @(posedge clk) begin
    for (int i = 1; i < DEPTH; i++) begin
      if (rst) begin
        regs[i] <= '0;
      end else if (wr_en[i]) begin
        regs[i] <= wdata;
      end
    end
  end

  // Row 0 is a constant zero so every index reads through one uniform mux.
  assign rows[0] = '0;
  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_rows
    assign rows[gi] = regs[gi];
  end

  // A write to x0 (onehot[0]) is never a live write and never forwarded.
  assign wr_live = (BYPASS != 0) && !rst && we && !onehot[0];
  assign byp1    = wr_live && (waddr == raddr1) && (raddr1 != ZERO_IDX);
  assign byp2    = wr_live && (waddr == raddr2) && (raddr2 != ZERO_IDX);

  assign rdata1   = rst ? '0 : (byp1 ? wdata : rows[raddr1]);
  assign rdata2   = rst ? '0 : (byp2 ? wdata : rows[raddr2]);
  assign dbg_data = rst ? '0 : rows[dbg_addr];

endmodule

// File: tb/tb_reg_file.sv
// Randomized and directed bench for reg_file; a BYPASS=1 and a BYPASS=0 build
// run side by side against an array-based model of the architectural state.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] rdata1, rdata2, dbg_data;
  logic [31:0] nb_rdata1, nb_rdata2, nb_dbg_data;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model [32];

  always #5 clk = ~clk;

  reg_file #(.DEPTH(32), .WIDTH(32), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  reg_file #(.DEPTH(32), .WIDTH(32), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(nb_rdata1), .rdata2(nb_rdata2),
    .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Architectural read value as seen before the coming edge.
  function automatic logic [31:0] ref_read(input logic [4:0] a, input bit fwd);
    if (rst) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (fwd && we && waddr == a) return wdata;
    return model[a];
  endfunction

  // Drive one cycle, check all outputs mid-cycle, then commit the model at the edge.
  task automatic apply(input logic r, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] da);
    rst = r; we = w; waddr = wa; wdata = wd;
    raddr1 = a1; raddr2 = a2; dbg_addr = da;
    @(negedge clk);
    check("byp_rdata1", rdata1,      ref_read(a1, 1'b1));
    check("byp_rdata2", rdata2,      ref_read(a2, 1'b1));
    check("byp_dbg",    dbg_data,    ref_read(da, 1'b0));
    check("nb_rdata1",  nb_rdata1,   ref_read(a1, 1'b0));
    check("nb_rdata2",  nb_rdata2,   ref_read(a2, 1'b0));
    check("nb_dbg",     nb_dbg_data, ref_read(da, 1'b0));
    $display("t=%0t rst=%b we=%b w[%0d]=%h r1[%0d]=%h r2[%0d]=%h dbg[%0d]=%h",
             $time, r, w, wa, wd, a1, rdata1, a2, rdata2, da, dbg_data);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (w && wa != 5'd0) begin
      model[wa] = wd;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Reset with a write pending: outputs zero, write dropped.
    apply(1, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd5);
    apply(1, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 5'd5);
    apply(0, 0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
    check("reset_dropped_write", dbg_data, 32'h0);

    // Sweep: each write read back on the following cycle via all ports.
    for (int i = 1; i < 32; i++)
      apply(0, 1, 5'(i), 32'h1000_0000 + i, 5'(i - 1), 5'(i - 1), 5'(i - 1));
    for (int i = 1; i < 32; i++) begin
      apply(0, 0, 5'd0, 32'h0, 5'(i), 5'(32 - i), 5'(i));
      check("sweep_dbg", dbg_data, 32'h1000_0000 + i);
    end

    // x0 stays zero and is never forwarded.
    apply(0, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    apply(0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);

    // Same-cycle forwarding versus committed-state reads.
    apply(0, 1, 5'd7, 32'h11, 5'd1, 5'd2, 5'd7);
    apply(0, 1, 5'd7, 32'h22, 5'd7, 5'd7, 5'd7);
    apply(0, 0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);
    check("bypass_commit", dbg_data, 32'h22);

    // Mid-run reset clears everything and drops the concurrent write.
    for (int i = 1; i < 32; i++)
      apply(0, 1, 5'(i), 32'hC000_0000 ^ (i * 32'h0101_0101), 5'd0, 5'd0, 5'd0);
    apply(1, 1, 5'd3, 32'h1234_5678, 5'd3, 5'd3, 5'd3);
    for (int i = 1; i < 32; i++) begin
      apply(0, 0, 5'd0, 32'h0, 5'(i), 5'(i), 5'(i));
      check("midreset_clear", nb_dbg_data, 32'h0);
    end
    apply(0, 1, 5'd3, 32'hA5, 5'd0, 5'd0, 5'd3);
    apply(0, 0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3);
    check("post_reset_write", rdata1, 32'hA5);

    // Random traffic; a narrow address pool makes read/write collisions common.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa, a1, a2, da;
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      wa = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      a1 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      a2 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      da = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      apply(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), wa,
            32'($urandom), a1, a2, da);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
